// File: rtl/vx_dcr_fifo_pkg.sv
// Shared defaults and helpers for the DCR write queue.
package vx_dcr_fifo_pkg;

  localparam int unsigned VX_DCR_ADDR_WIDTH_DEF = 8;
  localparam int unsigned VX_DCR_DATA_WIDTH_DEF = 32;
  localparam int unsigned VX_DCR_DEPTH_DEF      = 8;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int unsigned vx_dcr_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vx_dcr_fifo_ctrl.sv
// Pointer, full/empty, occupancy and high-water bookkeeping for vx_dcr_fifo.
module vx_dcr_fifo_ctrl
  import vx_dcr_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = VX_DCR_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     high_water
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = vx_dcr_ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ_q, occ_d;
  logic [PW-1:0] hw_q, hw_d;

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign occupancy  = occ_q;
  assign high_water = hw_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    hw_d     = hw_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
      hw_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      occ_d = occ_q + PW'(1);
      else if (pop && !push) occ_d = occ_q - PW'(1);
      hw_d = (occ_d > hw_q) ? occ_d : hw_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      hw_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      hw_q     <= hw_d;
    end
  end

endmodule

// File: rtl/vx_dcr_fifo.sv
// DCR write queue: buffers Piton-side (addr,data) writes and issues them to the Vortex DCR port.
module vx_dcr_fifo
  import vx_dcr_fifo_pkg::*;
#(
  parameter int unsigned VX_DCR_ADDR_WIDTH = VX_DCR_ADDR_WIDTH_DEF,
  parameter int unsigned VX_DCR_DATA_WIDTH = VX_DCR_DATA_WIDTH_DEF,
  parameter int unsigned DEPTH             = VX_DCR_DEPTH_DEF,
  parameter bit          FILTER_EN         = 1'b0,
  parameter int unsigned ADDR_LO           = 0,
  parameter int unsigned ADDR_HI           = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [VX_DCR_ADDR_WIDTH-1:0] in_addr,
  input  logic [VX_DCR_DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         dcr_wr_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] dcr_wr_data,
  input  logic                         dcr_busy,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [$clog2(DEPTH):0]       high_water,
  output logic                         overflow,
  output logic                         filtered
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int          Lo = int'(ADDR_LO);
  localparam int          Hi = int'(ADDR_HI);

  logic [VX_DCR_ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [VX_DCR_DATA_WIDTH-1:0] mem_data [DEPTH];

  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, empty;
  logic          accept, in_window, store;
  logic          overflow_q, filtered_q;
  int            addr_s;

  // Signed compare keeps the window test free of always-true unsigned bounds.
  assign addr_s    = int'(in_addr);
  assign in_window = !FILTER_EN || ((addr_s >= Lo) && (addr_s <= Hi));

  assign in_ready     = !full && !flush;
  assign accept       = in_valid && in_ready;
  assign store        = accept && in_window;
  assign dcr_wr_valid = !empty && !dcr_busy && !flush;
  assign dcr_wr_addr  = mem_addr[rd_idx];
  assign dcr_wr_data  = mem_data[rd_idx];
  assign overflow     = overflow_q;
  assign filtered     = filtered_q;

  vx_dcr_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .push       (store),
    .pop        (dcr_wr_valid),
    .flush      (flush),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .full       (full),
    .empty      (empty),
    .occupancy  (occupancy),
    .high_water (high_water)
  );

  always_ff @(posedge clk) begin
    if (store) begin
      mem_addr[wr_idx] <= in_addr;
      mem_data[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      filtered_q <= 1'b0;
    end else begin
      if (in_valid && !in_ready && !flush) overflow_q <= 1'b1;
      filtered_q <= accept && !in_window;
    end
  end

endmodule

// File: tb/tb_vx_dcr_fifo.sv
// Directed self-checking bench for vx_dcr_fifo (unfiltered and filtered instances).
module tb_vx_dcr_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        dcr_busy = 1'b0;

  logic        in_ready, dcr_wr_valid, overflow, filtered;
  logic [7:0]  dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic [3:0]  occupancy, high_water;

  logic        in_ready_f, dcr_wr_valid_f, overflow_f, filtered_f;
  logic [7:0]  dcr_wr_addr_f;
  logic [31:0] dcr_wr_data_f;
  logic [3:0]  occupancy_f, high_water_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_dcr_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .dcr_wr_valid(dcr_wr_valid),
    .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data), .dcr_busy(dcr_busy),
    .occupancy(occupancy), .high_water(high_water), .overflow(overflow), .filtered(filtered)
  );

  vx_dcr_fifo #(
    .FILTER_EN(1'b1), .ADDR_LO(32'h20), .ADDR_HI(32'h2F)
  ) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready_f), .flush(flush), .dcr_wr_valid(dcr_wr_valid_f),
    .dcr_wr_addr(dcr_wr_addr_f), .dcr_wr_data(dcr_wr_data_f), .dcr_busy(dcr_busy),
    .occupancy(occupancy_f), .high_water(high_water_f), .overflow(overflow_f),
    .filtered(filtered_f)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", dcr_wr_valid); end
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (high_water !== 4'd0) begin n_err++; $display("FAIL rst_hw: got %0d want 0", high_water); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_cmp++; if (filtered !== 1'b0) begin n_err++; $display("FAIL rst_filt: got %b want 0", filtered); end
    step();
    rst = 1'b0;
    step();
    // Mid-stream: queue three entries, then reset asynchronously between edges.
    dcr_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 8'h05 + 8'(i); in_data = 32'h500 + i;
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL mid_occ_pre: got %0d want 3", occupancy); end
    dcr_busy = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", dcr_wr_valid); end
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL mid_rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    #1 rst = 1'b0;
    step();
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b want 0", dcr_wr_valid); end
  endtask

  task automatic test_fill_drain();
    dcr_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 8'h10 + 8'(i); in_data = 32'hA000 + i;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ: got %0d want 8", occupancy); end
    n_cmp++; if (high_water !== 4'd8) begin n_err++; $display("FAIL full_hw: got %0d want 8", high_water); end
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL busy_valid: got %b want 0", dcr_wr_valid); end
    dcr_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (dcr_wr_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, dcr_wr_valid); end
      n_cmp++; if (dcr_wr_addr !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL drain_addr[%0d]: got %h want %h", i, dcr_wr_addr, 8'h10 + 8'(i)); end
      n_cmp++; if (dcr_wr_data !== 32'hA000 + i) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, dcr_wr_data, 32'hA000 + i); end
      step();
    end
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid: got %b want 0", dcr_wr_valid); end
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL drained_occ: got %0d want 0", occupancy); end
    n_cmp++; if (high_water !== 4'd8) begin n_err++; $display("FAIL drained_hw: got %0d want 8", high_water); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_addr [7];
    dcr_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 8'h40 + 8'(i); in_data = 32'hB000 + i;
      step();
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pre_ovf: got %b want 0", overflow); end
    // Full: hold a write while busy drops; the pop frees a slot for the next cycle only.
    in_addr = 8'h50; in_data = 32'hB050; dcr_busy = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
    n_cmp++; if (dcr_wr_valid !== 1'b1) begin n_err++; $display("FAIL full_pop_valid: got %b want 1", dcr_wr_valid); end
    n_cmp++; if (dcr_wr_addr !== 8'h40) begin n_err++; $display("FAIL full_pop_addr: got %h want 40", dcr_wr_addr); end
    step();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL ovf_occ: got %0d want 7", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ovf_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL pushpop_occ: got %0d want 7", occupancy); end
    for (int i = 0; i < 6; i++) exp_addr[i] = 8'h42 + 8'(i);
    exp_addr[6] = 8'h50;
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (dcr_wr_valid !== 1'b1 || dcr_wr_addr !== exp_addr[i]) begin
        n_err++; $display("FAIL ovf_drain[%0d]: got v=%b a=%h want v=1 a=%h", i, dcr_wr_valid, dcr_wr_addr, exp_addr[i]);
      end
      step();
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL ovf_end_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q [$];
    int sent = 0, got = 0, cyc = 0;
    while (got < 20 && cyc < 400) begin
      in_valid = (sent < 20);
      in_addr  = 8'h60 + 8'(sent);
      in_data  = 32'hC000 + sent;
      dcr_busy = 1'($urandom_range(0, 1));
      #1;
      if (dcr_wr_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL wrap_extra: got a=%h want no write", dcr_wr_addr);
        end else begin
          if (dcr_wr_addr !== exp_q[0] || dcr_wr_data !== 32'hC000 + 32'(exp_q[0] - 8'h60)) begin
            n_err++; $display("FAIL wrap_order[%0d]: got a=%h d=%h want a=%h", got, dcr_wr_addr, dcr_wr_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_addr);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; dcr_busy = 1'b0;
    n_cmp++; if (got != 20 || sent != 20) begin n_err++; $display("FAIL wrap_count: got out=%0d in=%0d want 20/20", got, sent); end
    #1;
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL wrap_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    dcr_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 8'h70 + 8'(i); in_data = 32'hD000 + i;
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL pre_flush_occ: got %0d want 5", occupancy); end
    flush = 1'b1; dcr_busy = 1'b0;
    #1;
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", dcr_wr_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    n_cmp++; if (high_water !== 4'd0) begin n_err++; $display("FAIL flush_hw: got %0d want 0", high_water); end
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", dcr_wr_valid); end
    in_valid = 1'b1; in_addr = 8'h7A; in_data = 32'hD07A;
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (dcr_wr_valid !== 1'b1 || dcr_wr_addr !== 8'h7A || dcr_wr_data !== 32'hD07A) begin
      n_err++; $display("FAIL flush_next: got v=%b a=%h d=%h want v=1 a=7a d=d07a", dcr_wr_valid, dcr_wr_addr, dcr_wr_data);
    end
    n_cmp++; if (high_water !== 4'd1) begin n_err++; $display("FAIL flush_next_hw: got %0d want 1", high_water); end
    step();
    n_cmp++; if (dcr_wr_valid !== 1'b0) begin n_err++; $display("FAIL flush_alone: got %b want 0", dcr_wr_valid); end
  endtask

  task automatic test_filter();
    logic [7:0] addrs [4];
    logic       exp_f [4];
    addrs[0] = 8'h1F; addrs[1] = 8'h20; addrs[2] = 8'h2F; addrs[3] = 8'h30;
    exp_f[0] = 1'b1;  exp_f[1] = 1'b0;  exp_f[2] = 1'b0;  exp_f[3] = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
    dcr_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = addrs[i]; in_data = 32'hE000 + i;
      #1;
      n_cmp++; if (in_ready_f !== 1'b1) begin n_err++; $display("FAIL filt_ready[%0d]: got %b want 1", i, in_ready_f); end
      step();
      n_cmp++; if (filtered_f !== exp_f[i]) begin n_err++; $display("FAIL filt_pulse[%0d]: got %b want %b", i, filtered_f, exp_f[i]); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (filtered_f !== 1'b0) begin n_err++; $display("FAIL filt_clear: got %b want 0", filtered_f); end
    n_cmp++; if (occupancy_f !== 4'd2) begin n_err++; $display("FAIL filt_occ: got %0d want 2", occupancy_f); end
    n_cmp++; if (occupancy !== 4'd4) begin n_err++; $display("FAIL nofilt_occ: got %0d want 4", occupancy); end
    dcr_busy = 1'b0;
    #1;
    n_cmp++; if (dcr_wr_valid_f !== 1'b1 || dcr_wr_addr_f !== 8'h20 || dcr_wr_data_f !== 32'hE001) begin
      n_err++; $display("FAIL filt_out0: got v=%b a=%h d=%h want v=1 a=20 d=e001", dcr_wr_valid_f, dcr_wr_addr_f, dcr_wr_data_f);
    end
    step();
    n_cmp++; if (dcr_wr_valid_f !== 1'b1 || dcr_wr_addr_f !== 8'h2F || dcr_wr_data_f !== 32'hE002) begin
      n_err++; $display("FAIL filt_out1: got v=%b a=%h d=%h want v=1 a=2f d=e002", dcr_wr_valid_f, dcr_wr_addr_f, dcr_wr_data_f);
    end
    step();
    n_cmp++; if (dcr_wr_valid_f !== 1'b0) begin n_err++; $display("FAIL filt_done: got %b want 0", dcr_wr_valid_f); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_wrap();
    test_flush();
    test_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
